ila_capture: RTL and testbench
==============================

Name: ila_capture

Overview:
- Parametrised, synthesizable successor to the single-channel time/value probe logger.
- Captures N_CH data channels plus a timestamp into an on-chip ring buffer, with decimation, a pre-trigger window and a post-trigger fill.
- After capture it streams the buffer out oldest-first over a valid/ready port to the host/CPU readout path, which converts fixed-point values to real numbers.
- Sits beside the emulated RX/TX signal path and taps the same time and filter-output buses.

Parameters:
TIME_WIDTH, 64, timestamp width in bits (fixed point, TIME_POINT fractional bits, interpreted downstream)
DATA_WIDTH, 18, width of each channel sample (signed fixed point, interpreted downstream)
N_CH, 2, number of captured channels
DEPTH, 1024, ring-buffer entries; power of two, at least 4
PRE_TRIG, 256, samples retained before the trigger sample; 0 to DEPTH-1
DECIM, 1, keep one of every DECIM valid samples; 1 to 65535

Ports:
clk  in  1  capture/readout clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample strobe; time_in and data_in are meaningful only when high
time_in  in  TIME_WIDTH  sample timestamp
data_in  in  N_CH*DATA_WIDTH  channel samples; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
arm  in  1  start a capture (single-cycle pulse)
abort  in  1  cancel the capture or readout and return to IDLE
trig  in  1  trigger qualifier, sampled only on qualified samples
rd_valid  out  1  readout entry valid
rd_ready  in  1  readout consumer ready
rd_time  out  TIME_WIDTH  timestamp of the current entry
rd_data  out  N_CH*DATA_WIDTH  samples of the current entry
rd_last  out  1  current entry is the final one of the dump
done  out  1  one-cycle pulse after the last entry handshakes
state  out  3  IDLE=0, PRE=1, ARMED=2, POST=3, DUMP=4

Behaviour:
- Reset:
  - state=IDLE; rd_valid, rd_last and done are 0.
  - rd_time and rd_data are 0.
  - All pointers and counters are 0. Buffer contents are undefined.
- Qualified sample:
  - A qualified sample is in_valid=1 AND decim_cnt=0.
  - decim_cnt decrements on every in_valid and reloads DECIM-1 when it is 0.
  - decim_cnt is cleared to 0 on arm, so the first valid sample after arm is qualified.
- Write:
  - Each qualified sample in PRE, ARMED or POST writes {time_in, data_in} at wr_ptr.
  - wr_ptr then increments modulo DEPTH (wraps silently).
- IDLE: arm -> PRE, with wr_ptr=0 and pre_cnt=0.
- PRE:
  - Each write increments pre_cnt.
  - When pre_cnt reaches PRE_TRIG, go to ARMED. If PRE_TRIG=0, go to ARMED on the cycle after arm.
  - trig is ignored in PRE.
- ARMED:
  - Writes continue, overwriting the oldest entries.
  - A qualified sample with trig=1 is written as the trigger entry.
  - start_ptr latches (trigger address - PRE_TRIG) mod DEPTH.
  - post_cnt loads DEPTH-PRE_TRIG-1.
  - Next state is POST, or DUMP if post_cnt is 0.
- POST:
  - Each write decrements post_cnt.
  - The write that brings post_cnt to 0 moves the state to DUMP on the next cycle.
  - trig is ignored in POST.
- DUMP:
  - Emits exactly DEPTH entries starting at start_ptr, incrementing modulo DEPTH.
  - rd_valid rises at most 2 cycles after entering DUMP.
  - Sustains 1 entry per cycle while rd_ready=1.
  - rd_time, rd_data and rd_last stay stable while rd_valid=1 and rd_ready=0.
  - in_valid is ignored during DUMP.
  - rd_last=1 only on entry DEPTH-1.
  - Handshake of the last entry: next cycle state=IDLE and done=1 for exactly one cycle.
- abort:
  - From any state, abort goes to IDLE on the next edge and clears rd_valid, rd_last and pointers.
  - done is not pulsed.
  - abort and arm in the same cycle: abort wins.
- arm outside IDLE is ignored.
- Reset asserted mid-capture or mid-dump: immediate return to the reset values above.
- Entry ordering is guaranteed only for DECIM-spaced qualified samples; timestamps are passed through unmodified.

Test Plan:
- DEPTH=8, PRE_TRIG=3, DECIM=1, N_CH=2. arm, continuous in_valid with time=0..; trig at time=10 -> dump times 7,8,9,10,11,12,13,14; rd_last on 14; done pulse one cycle after that handshake.
- Same configuration, DECIM=3, trig held high, valid samples at time=0..40 -> qualified times 0,3,6,...; dump 8 consecutive multiples of 3 with the trigger entry at dump position 3.
- PRE_TRIG=0, trig on the first qualified sample at time=5 -> dump 5..12; state passes IDLE->PRE->ARMED->POST->DUMP.
- rd_ready toggled 1,0,0,1 during the dump -> no entry lost or duplicated; outputs held while stalled; 8 handshakes total.
- abort raised in POST, then arm -> no done pulse; the new capture behaves exactly as a fresh one from time 0.
- rst_n pulsed low mid-DUMP with rd_valid=1 -> rd_valid=0 and state=0 immediately; a subsequent arm works normally.

Source files
------------

// File: rtl/ila_capture.sv
// ila_capture: multi-channel ring-buffer logic analyser with decimation, pre-trigger window and oldest-first readout.
module ila_capture #(
  parameter int TIME_WIDTH = 64,
  parameter int DATA_WIDTH = 18,
  parameter int N_CH       = 2,
  parameter int DEPTH      = 1024,
  parameter int PRE_TRIG   = 256,
  parameter int DECIM      = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [TIME_WIDTH-1:0]      time_in,
  input  logic [N_CH*DATA_WIDTH-1:0] data_in,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       trig,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [TIME_WIDTH-1:0]      rd_time,
  output logic [N_CH*DATA_WIDTH-1:0] rd_data,
  output logic                       rd_last,
  output logic                       done,
  output logic [2:0]                 state
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = TIME_WIDTH + N_CH*DATA_WIDTH;
  localparam logic [AW:0]   PRE_W   = (AW+1)'(PRE_TRIG);
  localparam logic [AW-1:0] PRE_A   = AW'(PRE_TRIG);
  localparam logic [AW-1:0] POST_LD = AW'(DEPTH - PRE_TRIG - 1);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [15:0]   DEC_LD  = 16'(DECIM - 1);

  typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3, DUMP = 3'd4} state_t;

  state_t          state_q, state_d;
  logic [15:0]     decim_q, decim_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]   post_cnt_q, post_cnt_d;
  logic [AW:0]     pre_cnt_q, pre_cnt_d;
  logic            rd_valid_q, rd_valid_d;
  logic            done_q, done_d;
  logic [EW-1:0]   dout_q;
  logic [EW-1:0]   mem [DEPTH];
  logic            arm_ok, we, hit, hs, fin;
  logic [AW-1:0]   raddr;

  always_comb begin
    arm_ok = (state_q == IDLE) && arm && !abort;
    we     = in_valid && (decim_q == '0) && (state_q == PRE || state_q == ARMED || state_q == POST);
    hit    = (state_q == ARMED) && we && trig;
    hs     = rd_valid_q && rd_ready;
    fin    = hs && (rd_cnt_q == LAST);
    raddr  = rd_ptr_q + AW'(hs);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (abort) state_d = IDLE;
    else
      case (state_q)
        IDLE:    if (arm) state_d = PRE;
        PRE:     if (PRE_TRIG == 0 || (we && pre_cnt_q + (AW+1)'(1) == PRE_W)) state_d = ARMED;
        ARMED:   if (hit) state_d = (POST_LD == '0) ? DUMP : POST;
        POST:    if (we && post_cnt_q == AW'(1)) state_d = DUMP;
        DUMP:    if (fin) state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end

  always_comb begin
    state    = state_q;
    rd_valid = rd_valid_q;
    rd_last  = rd_valid_q && (rd_cnt_q == LAST);
    done     = done_q;
    {rd_time, rd_data} = dout_q;
  end

  // The decimator is realigned on arm so the first valid sample of a capture is always kept.
  always_comb begin
    decim_d    = (arm_ok || abort) ? '0 : in_valid ? ((decim_q == '0) ? DEC_LD : decim_q - 16'd1) : decim_q;
    wr_ptr_d   = (arm_ok || abort) ? '0 : we ? wr_ptr_q + AW'(1) : wr_ptr_q;
    pre_cnt_d  = (arm_ok || abort) ? '0 : (we && state_q == PRE) ? pre_cnt_q + (AW+1)'(1) : pre_cnt_q;
    post_cnt_d = abort ? '0 : hit ? POST_LD : (we && state_q == POST) ? post_cnt_q - AW'(1) : post_cnt_q;
    rd_ptr_d   = abort ? '0 : hit ? wr_ptr_q - PRE_A : raddr;
    rd_cnt_d   = abort ? '0 : rd_cnt_q + AW'(hs);
    rd_valid_d = !abort && (state_q == DUMP) && !fin;
    done_d     = !abort && fin;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      decim_q    <= '0;
      wr_ptr_q   <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      decim_q    <= decim_d;
      wr_ptr_q   <= wr_ptr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end

  always_ff @(posedge clk)
    if (we) mem[wr_ptr_q] <= {time_in, data_in};

  // Read address looks ahead on a handshake so the output register refills every cycle; when stalled it re-reads the same entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                dout_q <= '0;
    else if (state_q == DUMP)  dout_q <= mem[raddr];
endmodule

// File: tb/tb_ila_capture.sv
// tb_ila_capture: directed scenarios on three configurations; dump entries are checked against a queue of expected timestamps.
module tb_ila_capture;
  logic        clk = 0, rst_n = 0, in_valid = 0, abort = 0, trig = 0, rd_ready = 0;
  logic [63:0] time_in = '0;
  logic [35:0] data_in = '0;
  logic        arm_v [3] = '{1'b0, 1'b0, 1'b0};
  logic        rv [3], rl [3], dn [3];
  logic [63:0] rt [3];
  logic [35:0] rdd [3];
  logic [2:0]  st [3];
  int          total = 0, bad = 0;
  int          exp_q [$];

  always #5 clk = ~clk;

  ila_capture #(.DEPTH(8), .PRE_TRIG(3), .DECIM(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .time_in(time_in), .data_in(data_in),
    .arm(arm_v[0]), .abort(abort), .trig(trig), .rd_valid(rv[0]), .rd_ready(rd_ready),
    .rd_time(rt[0]), .rd_data(rdd[0]), .rd_last(rl[0]), .done(dn[0]), .state(st[0]));
  ila_capture #(.DEPTH(8), .PRE_TRIG(3), .DECIM(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .time_in(time_in), .data_in(data_in),
    .arm(arm_v[1]), .abort(abort), .trig(trig), .rd_valid(rv[1]), .rd_ready(rd_ready),
    .rd_time(rt[1]), .rd_data(rdd[1]), .rd_last(rl[1]), .done(dn[1]), .state(st[1]));
  ila_capture #(.DEPTH(8), .PRE_TRIG(0), .DECIM(1)) u_p0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .time_in(time_in), .data_in(data_in),
    .arm(arm_v[2]), .abort(abort), .trig(trig), .rd_valid(rv[2]), .rd_ready(rd_ready),
    .rd_time(rt[2]), .rd_data(rdd[2]), .rd_last(rl[2]), .done(dn[2]), .state(st[2]));

  function automatic logic [35:0] fdat(input int t);
    return {18'(t * 7), 18'(t + 100)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input int a, input int step);
    for (int i = 0; i < 8; i++) exp_q.push_back(a + i * step);
  endtask

  task automatic do_arm(input int s);
    in_valid = 0;
    arm_v[s] = 1;
    tick;
    arm_v[s] = 0;
    chk("arm_to_pre", 64'(st[s]), 1);
  endtask

  // trig_at < 0 holds trig high on every sample
  task automatic feed(input int s, input int t0, input int trig_at, input logic [2:0] stop);
    int t;
    t = t0;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1;
      time_in  = 64'(t);
      data_in  = fdat(t);
      trig     = (trig_at < 0) || (t == trig_at);
      tick;
      t++;
      if (st[s] == stop) break;
    end
    in_valid = 0;
    trig = 0;
    chk("feed_reach_state", 64'(st[s]), 64'(stop));
  endtask

  task automatic drain(input int s, input bit stall);
    int hs_n, first, e;
    logic held, hl, fin;
    logic [63:0] ht;
    logic [35:0] hd;
    hs_n = 0; first = -1; held = 0; fin = 0; ht = '0; hd = '0; hl = 0;
    for (int c = 0; c < 60 && !fin; c++) begin
      rd_ready = stall ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      in_valid = 1;
      time_in  = 64'(5000 + c);
      data_in  = fdat(5000 + c);
      if (rv[s] && first < 0) first = c;
      if (held && rv[s]) begin
        chk("stall_time", rt[s], ht);
        chk("stall_data", 64'(rdd[s]), 64'(hd));
        chk("stall_last", 64'(rl[s]), 64'(hl));
      end
      held = rv[s] && !rd_ready;
      ht = rt[s]; hd = rdd[s]; hl = rl[s];
      if (rv[s] && rd_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        hs_n++;
        chk("rd_time", rt[s], 64'(e));
        chk("rd_data", 64'(rdd[s]), 64'(fdat(e)));
        chk("rd_last", 64'(rl[s]), 64'(exp_q.size() == 0));
        fin = (exp_q.size() == 0);
      end
      tick;
    end
    in_valid = 0;
    rd_ready = 0;
    chk("handshake_count", 64'(hs_n), 8);
    chk("first_valid_within_2", 64'(first >= 0 && first <= 2), 1);
    chk("idle_after_dump", 64'(st[s]), 0);
    chk("done_pulse", 64'(dn[s]), 1);
    tick;
    chk("done_one_cycle", 64'(dn[s]), 0);
    exp_q.delete();
  endtask

  initial begin
    tick;
    tick;
    for (int k = 0; k < 3; k++) begin
      chk("rst_state", 64'(st[k]), 0);
      chk("rst_rd_valid", 64'(rv[k]), 0);
      chk("rst_rd_last", 64'(rl[k]), 0);
      chk("rst_done", 64'(dn[k]), 0);
      chk("rst_rd_time", rt[k], 0);
      chk("rst_rd_data", 64'(rdd[k]), 0);
    end
    rst_n = 1;
    tick;

    // basic capture: trigger at time 10, three pre-trigger samples
    do_arm(0);
    push_seq(7, 1);
    feed(0, 0, 10, 3'd4);
    drain(0, 0);

    // decimation by 3 with trig held high from the start
    do_arm(1);
    push_seq(0, 3);
    feed(1, 0, -1, 3'd4);
    drain(1, 0);

    // zero pre-trigger window: PRE -> ARMED without samples, trigger on first sample
    do_arm(2);
    tick;
    chk("p0_armed", 64'(st[2]), 2);
    push_seq(5, 1);
    feed(2, 5, 5, 3'd3);
    feed(2, 6, 1000000, 3'd4);
    drain(2, 0);

    // back-pressure pattern 1,0,0,1 during the dump
    do_arm(0);
    push_seq(7, 1);
    feed(0, 0, 10, 3'd4);
    drain(0, 1);

    // abort in POST, then abort+arm together, then a fresh capture
    do_arm(0);
    feed(0, 0, 10, 3'd3);
    abort = 1;
    tick;
    abort = 0;
    chk("abort_state", 64'(st[0]), 0);
    chk("abort_done", 64'(dn[0]), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_no_done", 64'(dn[0]), 0);
    end
    arm_v[0] = 1;
    abort = 1;
    tick;
    arm_v[0] = 0;
    abort = 0;
    chk("abort_beats_arm", 64'(st[0]), 0);
    do_arm(0);
    push_seq(7, 1);
    feed(0, 0, 10, 3'd4);
    drain(0, 0);

    // asynchronous reset mid-dump, then a normal capture
    do_arm(0);
    feed(0, 0, 10, 3'd4);
    tick;
    chk("dump_valid_up", 64'(rv[0]), 1);
    rst_n = 0;
    #1;
    chk("async_rst_valid", 64'(rv[0]), 0);
    chk("async_rst_state", 64'(st[0]), 0);
    chk("async_rst_last", 64'(rl[0]), 0);
    chk("async_rst_time", rt[0], 0);
    tick;
    rst_n = 1;
    tick;
    do_arm(0);
    push_seq(7, 1);
    feed(0, 0, 10, 3'd4);
    drain(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
